// File: rtl/wb_traffic_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_traffic_gen_if
// Description : Wishbone classic bus bundle between the traffic generator
//               (master) and the SDRAM controller slave port.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_traffic_gen_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [AW-1:0]     wb_adr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW-1:0]     wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : wb_traffic_gen
// Description : Wishbone classic initiator that writes seed+i to a contiguous
//               address range, reads it back, and reports error count and
//               first failing address. Optional strobe timeout is enabled by
//               defining WB_TGEN_ACK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_traffic_gen #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int NW  = 16
`ifdef WB_TGEN_ACK_TIMEOUT_EN
    ,
    parameter int TMO = 255
`endif
) (
    input  wire logic          wb_clk_i,
    input  wire logic          wb_rst_i,
    input  wire logic          init_done,
    input  wire logic          start,
    input  wire logic [AW-1:0] base_adr,
    input  wire logic [NW-1:0] num_words,
    input  wire logic [DW-1:0] seed,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NW-1:0]      err_cnt,
    output logic [AW-1:0]      first_err_adr,
`ifdef WB_TGEN_ACK_TIMEOUT_EN
    output logic               timeout,
`endif
    wb_traffic_gen_if.master   wb
);

    localparam logic [AW-1:0] c_stride  = AW'(DW / 8);
    localparam logic [NW-1:0] c_err_max = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WGAP = 3'd2,
        S_RD   = 3'd3,
        S_RGAP = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t          r_state;
    logic            r_cyc, r_stb, r_we;
    logic [AW-1:0]   r_adr, r_base;
    logic [DW-1:0]   r_dat, r_seed;
    logic [NW-1:0]   r_num, r_idx;
    logic [NW-1:0]   r_err_cnt;
    logic [AW-1:0]   r_first_err_adr;
    logic            r_busy, r_done, r_pass;

    logic            w_term;
    logic            w_err_event;
    logic            w_timeout_hit;
    logic [NW-1:0]   w_idx_nxt;
    logic [NW-1:0]   w_err_cnt_inc;

`ifdef WB_TGEN_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1) + 1;
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_timeout;

    // Strobe-age counter: zero whenever the bus is idle or terminating.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_tmo_cnt <= '0;
        else if (!r_cyc || w_term)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_timeout_hit = r_cyc && !w_term && (r_tmo_cnt == TW'(TMO));
    assign timeout       = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Termination decode; err wins over a simultaneous ack.
    always_comb begin
        w_term        = r_cyc && (wb.wb_ack_i || wb.wb_err_i);
        w_err_event   = (r_cyc && wb.wb_err_i)
                      || (r_cyc && wb.wb_ack_i && !wb.wb_err_i && !r_we
                          && (wb.wb_dat_i != r_dat))
                      || w_timeout_hit;
        w_idx_nxt     = r_idx + 1'b1;
        w_err_cnt_inc = (r_err_cnt == c_err_max) ? r_err_cnt : r_err_cnt + 1'b1;
    end

    // Main sequencer: write pass, read-compare pass, then report.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state         <= S_IDLE;
            r_cyc           <= 1'b0;
            r_stb           <= 1'b0;
            r_we            <= 1'b0;
            r_adr           <= '0;
            r_dat           <= '0;
            r_base          <= '0;
            r_seed          <= '0;
            r_num           <= '0;
            r_idx           <= '0;
            r_err_cnt       <= '0;
            r_first_err_adr <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
`ifdef WB_TGEN_ACK_TIMEOUT_EN
            r_timeout       <= 1'b0;
`endif
        end else begin
            if (w_err_event) begin
                r_err_cnt <= w_err_cnt_inc;
                if (r_err_cnt == '0)
                    r_first_err_adr <= r_adr;
            end

            case (r_state)
                S_IDLE: begin
                    if (start && init_done) begin
                        r_base    <= base_adr;
                        r_num     <= num_words;
                        r_seed    <= seed;
                        r_adr     <= base_adr;
                        r_dat     <= seed;
                        r_idx     <= '0;
                        r_err_cnt <= '0;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef WB_TGEN_ACK_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        r_state   <= (num_words == '0) ? S_FIN : S_WR;
                    end
                end
                S_WR: begin
                    if (!r_cyc) begin
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_we  <= 1'b1;
                    end else if (w_term) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= S_WGAP;
                    end else if (w_timeout_hit) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
`ifdef WB_TGEN_ACK_TIMEOUT_EN
                        r_timeout <= 1'b1;
`endif
                        r_state <= S_FIN;
                    end
                end
                S_WGAP: begin
                    // Next strobe launches from the gap so a word costs 2 cycles.
                    r_cyc <= 1'b1;
                    r_stb <= 1'b1;
                    if (w_idx_nxt == r_num) begin
                        r_idx   <= '0;
                        r_adr   <= r_base;
                        r_dat   <= r_seed;
                        r_we    <= 1'b0;
                        r_state <= S_RD;
                    end else begin
                        r_idx   <= w_idx_nxt;
                        r_adr   <= r_adr + c_stride;
                        r_dat   <= r_dat + 1'b1;
                        r_we    <= 1'b1;
                        r_state <= S_WR;
                    end
                end
                S_RD: begin
                    if (w_term) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= S_RGAP;
                    end else if (w_timeout_hit) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
`ifdef WB_TGEN_ACK_TIMEOUT_EN
                        r_timeout <= 1'b1;
`endif
                        r_state <= S_FIN;
                    end
                end
                S_RGAP: begin
                    if (w_idx_nxt == r_num) begin
                        r_state <= S_FIN;
                    end else begin
                        r_idx   <= w_idx_nxt;
                        r_adr   <= r_adr + c_stride;
                        r_dat   <= r_dat + 1'b1;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= S_RD;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err_cnt == '0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wb.wb_cyc_o   = r_cyc;
    assign wb.wb_stb_o   = r_stb;
    assign wb.wb_we_o    = r_we;
    assign wb.wb_sel_o   = '1;
    assign wb.wb_adr_o   = r_adr;
    assign wb.wb_dat_o   = r_dat;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_adr = r_first_err_adr;

endmodule
`default_nettype wire

// File: tb/tb_wb_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_traffic_gen
// Description : Directed self-checking bench for wb_traffic_gen with a simple
//               Wishbone slave (one-cycle registered ack, word memory, fault
//               injection for corrupt data, bus error and no-ack).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_traffic_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        start;
    logic [31:0] base_adr;
    logic [15:0] num_words;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [31:0] first_err_adr;
`ifdef WB_TGEN_ACK_TIMEOUT_EN
    logic        timeout;
`endif

    int vectors     = 0;
    int miscompares = 0;

    wb_traffic_gen_if #(.DW(32), .AW(32)) bus ();

`ifdef WB_TGEN_ACK_TIMEOUT_EN
    wb_traffic_gen #(.DW(32), .AW(32), .NW(16), .TMO(15)) dut (
`else
    wb_traffic_gen #(.DW(32), .AW(32), .NW(16)) dut (
`endif
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .init_done     (init_done),
        .start         (start),
        .base_adr      (base_adr),
        .num_words     (num_words),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_adr (first_err_adr),
`ifdef WB_TGEN_ACK_TIMEOUT_EN
        .timeout       (timeout),
`endif
        .wb            (bus)
    );

    always #5 clk = ~clk;

    // Slave model controls
    logic        clr_log     = 1'b0;
    logic        corrupt_en  = 1'b0;
    logic [31:0] corrupt_adr = 32'h0;
    logic        err_en      = 1'b0;
    logic [31:0] err_adr     = 32'h0;
    logic        never_ack   = 1'b0;

    logic [31:0] mem [64];
    logic [31:0] wr_adr [32];
    logic [31:0] wr_dat [32];
    int          wr_n    = 0;
    int          rd_n    = 0;
    int          cyc_cnt = 0;

    // Slave: ack one cycle after strobe, log completed transfers.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_ack_i <= 1'b0;
            bus.wb_err_i <= 1'b0;
        end else begin
            bus.wb_ack_i <= 1'b0;
            bus.wb_err_i <= 1'b0;
            if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i && !bus.wb_err_i && !never_ack) begin
                bus.wb_ack_i <= 1'b1;
                if (err_en && bus.wb_we_o && bus.wb_adr_o == err_adr)
                    bus.wb_err_i <= 1'b1;
                if (bus.wb_we_o)
                    mem[bus.wb_adr_o[7:2]] <= bus.wb_dat_o;
                else
                    bus.wb_dat_i <= (corrupt_en && bus.wb_adr_o == corrupt_adr)
                                    ? 32'hDEAD_BEEF : mem[bus.wb_adr_o[7:2]];
            end
            if (clr_log) begin
                wr_n    <= 0;
                rd_n    <= 0;
                cyc_cnt <= 0;
            end else begin
                if (bus.wb_cyc_o)
                    cyc_cnt <= cyc_cnt + 1;
                if (bus.wb_cyc_o && bus.wb_ack_i) begin
                    if (bus.wb_we_o) begin
                        if (wr_n < 32) begin
                            wr_adr[wr_n] <= bus.wb_adr_o;
                            wr_dat[wr_n] <= bus.wb_dat_o;
                        end
                        wr_n <= wr_n + 1;
                    end else begin
                        rd_n <= rd_n + 1;
                    end
                end
            end
        end
    end

    task automatic issue_start(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
        @(negedge clk);
        base_adr  = b;
        num_words = n;
        seed      = s;
        start     = 1'b1;
        clr_log   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        clr_log = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, cycles);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        vectors++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, busy, done, pass} !== 6'b0) begin
            miscompares++;
            $display("FAIL %s_ctrl: cyc/stb/we/busy/done/pass=%b, required 000000", tag,
                     {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, busy, done, pass});
        end
        vectors++;
        if ({err_cnt, first_err_adr, bus.wb_adr_o, bus.wb_dat_o} !== 112'h0) begin
            miscompares++;
            $display("FAIL %s_data: err_cnt=%h first=%h adr=%h dat=%h, required all 0", tag,
                     err_cnt, first_err_adr, bus.wb_adr_o, bus.wb_dat_o);
        end
    endtask

    task automatic test_reset;
        check_idle_outputs("reset");
        vectors++;
        if (bus.wb_sel_o !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_sel: got %h, required f", bus.wb_sel_o);
        end
    endtask

    task automatic test_basic;
        int cyc;
        issue_start(32'h0000_0100, 16'd8, 32'hA5A5_0000);
        vectors++;
        if (bus.wb_cyc_o !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_lat_t: cyc=%b busy=%b, required cyc=0 busy=1", bus.wb_cyc_o, busy);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.wb_cyc_o !== 1'b1 || bus.wb_we_o !== 1'b1 || bus.wb_adr_o !== 32'h100) begin
            miscompares++;
            $display("FAIL basic_lat_t1: cyc=%b we=%b adr=%h, required 1 1 00000100",
                     bus.wb_cyc_o, bus.wb_we_o, bus.wb_adr_o);
        end
        wait_done(cyc);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (wr_adr[i] !== 32'h100 + 32'(i * 4) || wr_dat[i] !== 32'hA5A5_0000 + 32'(i)) begin
                miscompares++;
                $display("FAIL basic_wr%0d: adr=%h dat=%h, required %h %h", i, wr_adr[i], wr_dat[i],
                         32'h100 + 32'(i * 4), 32'hA5A5_0000 + 32'(i));
            end
        end
        vectors++;
        if (wr_n !== 8 || rd_n !== 8 || pass !== 1'b1 || err_cnt !== 16'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: wr=%0d rd=%0d pass=%b err=%0d busy=%b, required 8 8 1 0 0",
                     wr_n, rd_n, pass, err_cnt, busy);
        end
    endtask

    task automatic test_corrupt;
        int cyc;
        corrupt_en  = 1'b1;
        corrupt_adr = 32'h0000_010C;
        issue_start(32'h0000_0100, 16'd8, 32'hA5A5_0000);
        wait_done(cyc);
        corrupt_en = 1'b0;
        vectors++;
        if (err_cnt !== 16'd1 || first_err_adr !== 32'h10C || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL corrupt: err=%0d first=%h pass=%b, required 1 0000010c 0",
                     err_cnt, first_err_adr, pass);
        end
    endtask

    task automatic test_zero_words;
        int cyc;
        issue_start(32'h0000_0200, 16'd0, 32'h1234_5678);
        wait_done(cyc);
        vectors++;
        if (cyc > 3 || pass !== 1'b1 || cyc_cnt !== 0) begin
            miscompares++;
            $display("FAIL zero_words: cycles=%0d pass=%b cyc_seen=%0d, required <=3 1 0",
                     cyc, pass, cyc_cnt);
        end
    endtask

    task automatic test_wrap;
        int cyc;
        issue_start(32'hFFFF_FFFC, 16'd2, 32'hFFFF_FFFF);
        wait_done(cyc);
        vectors++;
        if (wr_adr[0] !== 32'hFFFF_FFFC || wr_dat[0] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL wrap_w0: adr=%h dat=%h, required fffffffc ffffffff", wr_adr[0], wr_dat[0]);
        end
        vectors++;
        if (wr_adr[1] !== 32'h0 || wr_dat[1] !== 32'h0 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_w1: adr=%h dat=%h pass=%b, required 0 0 1", wr_adr[1], wr_dat[1], pass);
        end
    endtask

    task automatic test_bus_err;
        int cyc;
        err_en  = 1'b1;
        err_adr = 32'h0000_0108;
        issue_start(32'h0000_0100, 16'd8, 32'h1234_0000);
        wait_done(cyc);
        err_en = 1'b0;
        vectors++;
        if (err_cnt !== 16'd1 || first_err_adr !== 32'h108 || pass !== 1'b0 || rd_n !== 8) begin
            miscompares++;
            $display("FAIL bus_err: err=%0d first=%h pass=%b rd=%0d, required 1 00000108 0 8",
                     err_cnt, first_err_adr, pass, rd_n);
        end
    endtask

    task automatic test_start_busy;
        int cyc;
        issue_start(32'h0000_0100, 16'd4, 32'h1111_0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        base_adr  = 32'h0000_0080;
        num_words = 16'd8;
        seed      = 32'h0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        vectors++;
        if (wr_n !== 4 || rd_n !== 4 || wr_adr[3] !== 32'h10C || wr_dat[3] !== 32'h1111_0003 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL start_busy: wr=%0d rd=%0d adr3=%h dat3=%h pass=%b, required 4 4 0000010c 11110003 1",
                     wr_n, rd_n, wr_adr[3], wr_dat[3], pass);
        end
    endtask

    task automatic test_no_init;
        init_done = 1'b0;
        issue_start(32'h0000_0100, 16'd4, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || cyc_cnt !== 0) begin
            miscompares++;
            $display("FAIL no_init: busy=%b cyc_seen=%0d, required 0 0", busy, cyc_cnt);
        end
        init_done = 1'b1;
    endtask

    task automatic test_reset_mid;
        int cyc;
        int n;
        issue_start(32'h0000_0040, 16'd16, 32'h5A00_0000);
        n = 0;
        while (!(rd_n == 5 && bus.wb_cyc_o === 1'b1) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (rd_n !== 5 || bus.wb_cyc_o !== 1'b1 || bus.wb_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_reach: rd=%0d cyc=%b we=%b, required 5 1 0", rd_n, bus.wb_cyc_o, bus.wb_we_o);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_async: cyc=%b stb=%b, required 0 0", bus.wb_cyc_o, bus.wb_stb_o);
        end
        check_idle_outputs("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        issue_start(32'h0000_0040, 16'd16, 32'h5A00_0000);
        wait_done(cyc);
        vectors++;
        if (wr_n !== 16 || rd_n !== 16 || pass !== 1'b1 || err_cnt !== 16'd0 || wr_dat[15] !== 32'h5A00_000F) begin
            miscompares++;
            $display("FAIL reset_rerun: wr=%0d rd=%0d pass=%b err=%0d dat15=%h, required 16 16 1 0 5a00000f",
                     wr_n, rd_n, pass, err_cnt, wr_dat[15]);
        end
    endtask

`ifdef WB_TGEN_ACK_TIMEOUT_EN
    task automatic test_timeout;
        int cyc;
        never_ack = 1'b1;
        issue_start(32'h0000_0100, 16'd4, 32'h0);
        wait_done(cyc);
        never_ack = 1'b0;
        vectors++;
        if (timeout !== 1'b1 || err_cnt !== 16'd1 || first_err_adr !== 32'h100 || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_flags: tmo=%b err=%0d first=%h pass=%b, required 1 1 00000100 0",
                     timeout, err_cnt, first_err_adr, pass);
        end
        vectors++;
        if (cyc_cnt !== 16 || rd_n !== 0 || wr_n !== 0) begin
            miscompares++;
            $display("FAIL timeout_bus: strobe_cycles=%0d rd=%0d wr=%0d, required 16 0 0", cyc_cnt, rd_n, wr_n);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        init_done = 1'b1;
        start     = 1'b0;
        base_adr  = 32'h0;
        num_words = 16'h0;
        seed      = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        test_basic;
        test_corrupt;
        test_zero_words;
        test_wrap;
        test_bus_err;
        test_start_busy;
        test_no_init;
        test_reset_mid;
`ifdef WB_TGEN_ACK_TIMEOUT_EN
        test_timeout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_traffic_gen.md
Name: wb_traffic_gen

Overview:
- Synthesizable Wishbone classic initiator that exercises the SDRAM controller's Wishbone slave port.
- On a start command it writes a deterministic pattern to a contiguous address range, reads the range back and compares each word.
- Reports completion, error count and first failing address.
- Sits on the Wishbone bus in place of the behavioural bench master; used for self-checking bring-up.

Parameters:
- dw, 32: Wishbone data width in bits; multiple of 8.
- aw, 32: Wishbone byte-address width.
- nw, 16: width of the word-count and error-count fields.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  asynchronous active-high reset.
- init_done  in  1  SDRAM initialisation complete; start ignored while low.
- start  in  1  single-cycle start pulse.
- base_adr  in  aw  first byte address, sampled at start.
- num_words  in  nw  words to write and then read, sampled at start.
- seed  in  dw  pattern seed, sampled at start.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next accepted start.
- pass  out  1  valid when done; 1 if err_cnt==0.
- err_cnt  out  nw  mismatches plus bus errors; saturating.
- first_err_adr  out  aw  byte address of the first error.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  1=write.
- wb_sel_o  out  dw/8  byte selects; always all ones.
- wb_adr_o  out  aw  byte address.
- wb_dat_o  out  dw  write data.
- wb_dat_i  in  dw  read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error termination.

Behaviour:
- Reset (asynchronous, immediate):
  - cyc, stb, we, busy, done and pass are 0; err_cnt is 0; first_err_adr, adr and dat_o are 0.
  - State is IDLE.
  - Reset mid-transfer drops cyc/stb without waiting for ack.
- Pattern: word i (0-based) = seed + i, modulo 2^dw. Address of word i = base_adr + i*(dw/8), wrapping modulo 2^aw.
- States:
  - IDLE: on start & init_done, sample inputs, clear err_cnt/done/pass, set busy. If num_words==0 go to FIN, else go to WR.
  - WR:
    - cyc=stb=we=1 with adr/dat of word i, held stable until a termination (ack or err) is sampled.
    - On termination, deassert cyc/stb next cycle and go to WGAP.
    - err on a write increments err_cnt.
  - WGAP:
    - One idle bus cycle; increment i.
    - If i==num_words, reset i=0 and go to RD; else go to WR.
  - RD:
    - cyc=stb=1, we=0.
    - On ack, compare wb_dat_i with the expected word; on mismatch increment err_cnt.
    - On err, increment err_cnt with no compare.
    - Then go to RGAP.
  - RGAP: one idle cycle; increment i. If i==num_words go to FIN, else go to RD.
  - FIN: busy=0, done=1, pass=(err_cnt==0); return to IDLE.
- Latency:
  - start at edge t gives cyc_o=1 after edge t+1.
  - Minimum 2 cycles per word when ack returns in the first strobe cycle.
- Termination precedence: ack and err in the same cycle is treated as err only.
- err_cnt saturates at 2^nw-1.
- first_err_adr is captured only when err_cnt transitions from 0.
- start while busy is ignored; start while init_done=0 is ignored.
- wb_ack_i/wb_err_i while cyc_o=0 are ignored.

Optional Feature:
- Macro WB_TGEN_ACK_TIMEOUT_EN.
- Defined:
  - Parameter tmo (default 255) is added, with a cycle counter that resets at each strobe assertion.
  - If no ack/err within tmo cycles of strobe, drop cyc/stb, increment err_cnt, capture first_err_adr if first error, and set output timeout (1 bit, cleared on start).
  - The state machine then goes directly to FIN, abandoning remaining words.
- Undefined: no counter and no timeout port; the master waits indefinitely for termination.

Test Plan:
- Basic: base_adr=0x0000_0100, num_words=8, seed=0xA5A5_0000, slave acks after 1 cycle.
  - Writes 0xA5A5_0000..0xA5A5_0007 to 0x100..0x11C.
  - 8 reads follow; done=1, pass=1, err_cnt=0.
- Corrupt read: slave returns 0xDEAD_BEEF for word 3 of the test above.
  - err_cnt=1, first_err_adr=0x10C, pass=0.
- Edge cases:
  - num_words=0 gives done=1 and pass=1 within 3 cycles, with cyc_o never asserted.
  - base_adr=0xFFFF_FFFC with num_words=2 puts the second address at 0x0000_0000.
  - seed=0xFFFF_FFFF gives word1=0x0000_0000.
- Bus error and start handling:
  - wb_err_i on write 2 (ack also high) counts one error, err_cnt=1.
  - start while busy=1 leaves the sampled parameters unchanged.
  - start with init_done=0 leaves busy at 0.
- Reset: assert wb_rst_i during RD word 5 of 16.
  - cyc_o/stb_o go low without a clock edge; all outputs return to their reset values.
  - A new start then runs a full clean test.
- Timeout (macro defined): tmo=15, slave never acks word 0.
  - timeout=1 and err_cnt=1 after 16 cycles of strobe; done=1, and no read phase is performed.
